// File: rtl/input_debouncer_if.sv
// Signal bundle between a raw input source and the debouncer.
// master drives the raw input; slave (the debouncer) returns the conditioned level and edge pulses.
interface input_debouncer_if;
    logic din;
    logic dout;
    logic rise;
    logic fall;
    logic busy;

    modport master (
        output din,
        input  dout,
        input  rise,
        input  fall,
        input  busy
    );

    modport slave (
        input  din,
        output dout,
        output rise,
        output fall,
        output busy
    );
endinterface

// File: rtl/input_debouncer.sv
// Synchronizes a raw asynchronous bit, qualifies changes over STABLE_CYCLES samples,
// and emits a registered debounced level with one-cycle rise/fall pulses.
module input_debouncer #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input_debouncer_if.slave  bus
);
    localparam int               CNT_W    = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    if (SYNC_STAGES < 2) begin : g_bad_sync_stages
        $error("input_debouncer: SYNC_STAGES must be >= 2");
    end
    if (STABLE_CYCLES < 1) begin : g_bad_stable_cycles
        $error("input_debouncer: STABLE_CYCLES must be >= 1");
    end

    logic [SYNC_STAGES-1:0] sync;
    logic [CNT_W-1:0]       cnt;
    logic                   dout_q;
    logic                   rise_q;
    logic                   fall_q;
    logic                   s;
    logic                   mismatch;
    logic                   at_last;

    // Plain flop chain: nothing may sit between stages or metastability can leak through.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], bus.din};
        end
    end

    always_comb begin
        s        = sync[SYNC_STAGES-1];
        mismatch = (s != dout_q);
        at_last  = (cnt == CNT_LAST);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            dout_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= mismatch & s & at_last;
            fall_q <= mismatch & ~s & at_last;
            if (!mismatch) begin
                cnt <= '0;
            end else if (at_last) begin
                dout_q <= s;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign bus.dout = dout_q;
    assign bus.rise = rise_q;
    assign bus.fall = fall_q;
    assign bus.busy = (cnt != '0);
endmodule

// File: tb/tb_input_debouncer.sv
// Self-checking bench for input_debouncer: directed scenarios plus randomized input
// checked against a sliding-window reference model.
module tb_input_debouncer;
    localparam int SS1 = 2;
    localparam int SC1 = 4;
    localparam int SS2 = 3;
    localparam int SC2 = 1;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   vectors     = 0;
    int   miscompares = 0;

    input_debouncer_if bus1();
    input_debouncer_if bus2();

    input_debouncer #(.SYNC_STAGES(SS1), .STABLE_CYCLES(SC1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    input_debouncer #(.SYNC_STAGES(SS2), .STABLE_CYCLES(SC2)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    always #5 clk = ~clk;

    // Reference model: dout flips when the last SC1 synchronized samples all disagree with it.
    bit pipe_q[$];
    bit s_win[$];
    bit m_dout, m_rise, m_fall, m_busy;
    bit rst_at_edge = 1'b1;

    always @(posedge clk) begin : model
        bit s;
        bit all_diff;
        rst_at_edge = reset;
        if (reset) begin
            pipe_q.delete();
            for (int i = 0; i < SS1; i++) pipe_q.push_back(1'b0);
            s_win.delete();
            m_dout = 1'b0;
            m_rise = 1'b0;
            m_fall = 1'b0;
            m_busy = 1'b0;
        end else begin
            s = pipe_q.pop_front();
            pipe_q.push_back(bus1.din);
            s_win.push_back(s);
            if (s_win.size() > SC1) void'(s_win.pop_front());
            all_diff = (s_win.size() == SC1);
            foreach (s_win[i]) if (s_win[i] == m_dout) all_diff = 1'b0;
            m_rise = all_diff && s;
            m_fall = all_diff && !s;
            if (all_diff) m_dout = s;
            m_busy = (s_win[$] != m_dout);
        end
    end

    // Properties that must hold on every cycle for both instances.
    logic p_dout1 = 1'b0, p_rise1 = 1'b0, p_dout2 = 1'b0, p_rise2 = 1'b0;
    always @(negedge clk) begin
        vectors++;
        if (bus1.rise === 1'b1 && bus1.fall === 1'b1) begin
            miscompares++;
            $display("FAIL excl1: rise=%b fall=%b, required not both high", bus1.rise, bus1.fall);
        end
        vectors++;
        if (p_rise1 === 1'b1 && bus1.rise === 1'b1) begin
            miscompares++;
            $display("FAIL width1: rise=%b on consecutive cycles, required 0", bus1.rise);
        end
        vectors++;
        if (bus2.rise === 1'b1 && bus2.fall === 1'b1) begin
            miscompares++;
            $display("FAIL excl2: rise=%b fall=%b, required not both high", bus2.rise, bus2.fall);
        end
        vectors++;
        if (p_rise2 === 1'b1 && bus2.rise === 1'b1) begin
            miscompares++;
            $display("FAIL width2: rise=%b on consecutive cycles, required 0", bus2.rise);
        end
        if (!rst_at_edge) begin
            vectors++;
            if ((bus1.dout !== p_dout1) !== (bus1.rise || bus1.fall)) begin
                miscompares++;
                $display("FAIL chg1: dout %b->%b with rise=%b fall=%b, required change iff pulse",
                         p_dout1, bus1.dout, bus1.rise, bus1.fall);
            end
            vectors++;
            if ((bus2.dout !== p_dout2) !== (bus2.rise || bus2.fall)) begin
                miscompares++;
                $display("FAIL chg2: dout %b->%b with rise=%b fall=%b, required change iff pulse",
                         p_dout2, bus2.dout, bus2.rise, bus2.fall);
            end
        end
        p_dout1 = bus1.dout;
        p_rise1 = bus1.rise;
        p_dout2 = bus2.dout;
        p_rise2 = bus2.rise;
    end

    task automatic test_reset();
        reset    = 1'b1;
        bus1.din = 1'b1;
        for (int e = 0; e < 3; e++) begin
            @(negedge clk);
            vectors++;
            if ({bus1.dout, bus1.rise, bus1.fall, bus1.busy} !== 4'b0000) begin
                miscompares++;
                $display("FAIL reset_hold: dout,rise,fall,busy=%b%b%b%b, required 0000",
                         bus1.dout, bus1.rise, bus1.fall, bus1.busy);
            end
        end
        reset = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            @(negedge clk);
            vectors++;
            if (bus1.rise !== 1'(e == 6)) begin
                miscompares++;
                $display("FAIL reset_rise e%0d: rise=%b, required %b", e, bus1.rise, e == 6);
            end
            vectors++;
            if (bus1.dout !== 1'(e >= 6)) begin
                miscompares++;
                $display("FAIL reset_dout e%0d: dout=%b, required %b", e, bus1.dout, e >= 6);
            end
            vectors++;
            if (bus1.busy !== 1'(e >= 3 && e <= 5)) begin
                miscompares++;
                $display("FAIL reset_busy e%0d: busy=%b, required %b", e, bus1.busy, e >= 3 && e <= 5);
            end
        end
    endtask

    task automatic test_clean_step();
        for (int v = 0; v < 2; v++) begin
            logic val;
            val      = (v == 1);
            bus1.din = val;
            for (int e = 1; e <= 8; e++) begin
                @(negedge clk);
                vectors++;
                if (bus1.dout !== ((e >= 6) ? val : !val)) begin
                    miscompares++;
                    $display("FAIL step_dout v%0d e%0d: dout=%b, required %b", val, e, bus1.dout,
                             (e >= 6) ? val : !val);
                end
                vectors++;
                if ({bus1.rise, bus1.fall} !== {val && e == 6, !val && e == 6}) begin
                    miscompares++;
                    $display("FAIL step_pulse v%0d e%0d: rise,fall=%b%b, required %b%b", val, e,
                             bus1.rise, bus1.fall, val && e == 6, !val && e == 6);
                end
                vectors++;
                if (bus1.busy !== 1'(e >= 3 && e <= 5)) begin
                    miscompares++;
                    $display("FAIL step_busy v%0d e%0d: busy=%b, required %b", val, e, bus1.busy,
                             e >= 3 && e <= 5);
                end
            end
        end
    endtask

    task automatic test_glitch_reject();
        logic saw_busy;
        saw_busy = 1'b0;
        bus1.din = 1'b0;
        repeat (8) @(negedge clk);
        vectors++;
        if (bus1.dout !== 1'b0) begin
            miscompares++;
            $display("FAIL glitch_setup: dout=%b, required 0", bus1.dout);
        end
        bus1.din = 1'b1;
        repeat (3) @(negedge clk);
        bus1.din = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            @(negedge clk);
            if (bus1.busy === 1'b1) saw_busy = 1'b1;
            vectors++;
            if (bus1.dout !== 1'b0 || bus1.rise !== 1'b0) begin
                miscompares++;
                $display("FAIL glitch e%0d: dout=%b rise=%b, required 0 0", e, bus1.dout, bus1.rise);
            end
        end
        vectors++;
        if (bus1.busy !== 1'b0 || saw_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL glitch_busy: final busy=%b seen=%b, required 0 1", bus1.busy, saw_busy);
        end
    endtask

    task automatic test_chatter();
        for (int i = 0; i < 10; i++) begin
            bus1.din = (i % 2 == 0);
            repeat (2) begin
                @(negedge clk);
                vectors++;
                if ({bus1.dout, bus1.rise, bus1.fall} !== 3'b000) begin
                    miscompares++;
                    $display("FAIL chatter seg%0d: dout,rise,fall=%b%b%b, required 000", i,
                             bus1.dout, bus1.rise, bus1.fall);
                end
            end
        end
        bus1.din = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            @(negedge clk);
            vectors++;
            if (bus1.rise !== 1'(e == 6) || bus1.dout !== 1'(e >= 6)) begin
                miscompares++;
                $display("FAIL chatter_hold e%0d: rise=%b dout=%b, required %b %b", e,
                         bus1.rise, bus1.dout, e == 6, e >= 6);
            end
        end
    endtask

    task automatic test_reset_mid();
        bus1.din = 1'b0;
        repeat (4) @(negedge clk);
        vectors++;
        if (bus1.busy !== 1'b1 || bus1.dout !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_setup: busy=%b dout=%b, required 1 1", bus1.busy, bus1.dout);
        end
        reset    = 1'b1;
        bus1.din = 1'b1;
        @(negedge clk);
        vectors++;
        if ({bus1.dout, bus1.rise, bus1.fall, bus1.busy} !== 4'b0000) begin
            miscompares++;
            $display("FAIL mid_reset: dout,rise,fall,busy=%b%b%b%b, required 0000",
                     bus1.dout, bus1.rise, bus1.fall, bus1.busy);
        end
        reset = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            @(negedge clk);
            vectors++;
            if (bus1.rise !== 1'(e == 6) || bus1.dout !== 1'(e >= 6) ||
                bus1.busy !== 1'(e >= 3 && e <= 5)) begin
                miscompares++;
                $display("FAIL mid_restart e%0d: rise=%b dout=%b busy=%b, required %b %b %b", e,
                         bus1.rise, bus1.dout, bus1.busy, e == 6, e >= 6, e >= 3 && e <= 5);
            end
        end
    endtask

    task automatic test_random();
        int hold;
        hold = 0;
        for (int n = 0; n < 600; n++) begin
            if (hold == 0) begin
                bus1.din = 1'($urandom_range(0, 1));
                hold     = int'($urandom_range(1, 7));
            end
            hold--;
            reset = ($urandom_range(0, 99) == 0);
            @(negedge clk);
            vectors++;
            if ({bus1.dout, bus1.rise, bus1.fall, bus1.busy} !== {m_dout, m_rise, m_fall, m_busy}) begin
                miscompares++;
                $display("FAIL random n%0d: dout,rise,fall,busy=%b%b%b%b, required %b%b%b%b", n,
                         bus1.dout, bus1.rise, bus1.fall, bus1.busy, m_dout, m_rise, m_fall, m_busy);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_params();
        int  edges;
        bit  hist[$];
        logic exp_d, prev_d;
        for (int v = 0; v < 2; v++) begin
            logic val;
            val      = (v == 0);
            bus2.din = val;
            edges    = 0;
            for (int e = 1; e <= 10 && edges == 0; e++) begin
                @(negedge clk);
                if (bus2.dout === val) begin
                    edges = e;
                    vectors++;
                    if ({bus2.rise, bus2.fall} !== {val, !val}) begin
                        miscompares++;
                        $display("FAIL param_pulse v%0d: rise,fall=%b%b, required %b%b", val,
                                 bus2.rise, bus2.fall, val, !val);
                    end
                end
            end
            vectors++;
            if (edges != SS2 + SC2) begin
                miscompares++;
                $display("FAIL param_latency v%0d: %0d edges, required %0d", val, edges, SS2 + SC2);
            end
        end
        repeat (SS2 + SC2) hist.push_back(1'b0);
        prev_d = 1'b0;
        for (int n = 0; n < 60; n++) begin
            bus2.din = 1'($urandom_range(0, 1));
            hist.push_back(bus2.din);
            @(negedge clk);
            exp_d = hist[hist.size() - (SS2 + SC2)];
            vectors++;
            if (bus2.dout !== exp_d || bus2.rise !== (exp_d && !prev_d)) begin
                miscompares++;
                $display("FAIL param_follow n%0d: dout=%b rise=%b, required %b %b", n,
                         bus2.dout, bus2.rise, exp_d, exp_d && !prev_d);
            end
            prev_d = exp_d;
        end
        bus2.din = 1'b0;
    endtask

    initial begin
        bus1.din = 1'b0;
        bus2.din = 1'b0;
        test_reset();
        test_clean_step();
        test_glitch_reject();
        test_chatter();
        test_reset_mid();
        test_random();
        test_params();
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
